seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised serial sequence detector: the configurable successor to the fixed 1101 pattern FSM in the FSM examples. It takes one serial bit per qualified clock and pulses its output when the most recent bits match a runtime-programmable pattern of programmable length. It supports overlapping and non-overlapping detection and keeps an optional saturating match counter. It sits directly behind a serial input source and drives a single-cycle match strobe to downstream logic.

## Interface
- MAX_LEN, 8: maximum pattern length in bits, range 2..32.
- CNT_W, 8: width of the match counter.
- LEN_W, $clog2(MAX_LEN+1): width of `cfg_len`; this is a derived parameter and is not overridden.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset; synchronous, active-low.
- i  in  1  serial data bit.
- in_valid  in  1  qualifies `i`. When low, the bit is ignored and state is held.
- cfg_load  in  1  one-cycle strobe that latches `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- cfg_pattern  in  MAX_LEN  pattern, right-aligned. Bit `[len-1]` is the first bit expected.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- o  out  1  match strobe; high for one cycle per match.
- match_cnt  out  CNT_W  saturating match count (see Configuration).

## Operation
- **Shadow config registers:** `pat_q`, `len_q`, `ovl_q`. Reset values are `pat_q = 'b1101` (zero-extended), `len_q = 4`, `ovl_q = 1`, so behaviour out of reset equals the legacy 1101 detector.
- **Length rules applied on load:**
  - `cfg_len > MAX_LEN` is clamped to MAX_LEN.
  - `cfg_len == 0` disables detection: `o` stays 0 and `match_cnt` holds.
- **Datapath registers:**
  - `hist`: MAX_LEN-bit shift register. On a valid bit, `hist <= {hist[MAX_LEN-2:0], i}`.
  - `fill`: LEN_W-bit count of valid bits since the last clear, saturating at MAX_LEN.
- **Match condition:** a valid bit causes a match when `fill + 1 >= len_q` and the low `len_q` bits of the shifted history equal the low `len_q` bits of `pat_q`. Bits of `pat_q` above `len_q` are ignored.
- **Overlap mode (`ovl_q = 1`):** history is retained after a match. A suffix of one match can form the prefix of the next.
- **Non-overlap mode (`ovl_q = 0`):** on a match, `fill` is cleared to 0 and matching restarts from the next valid bit.
- **Clear operation:** `hist` and `fill` go to 0; the counter is not affected.
- **cfg_load:** the config registers take the new values and a clear is performed. Any `i`/`in_valid` presented in the same cycle is discarded.
- **Reset (rst = 0):** all registers return to their reset values, including mid-stream. Reset has priority over `cfg_load` and `in_valid`.
- **Outputs at reset:** `o = 0`, `match_cnt = 0`.
- Controller states are IDLE (`fill == 0`), FILLING (`0 < fill < len_q`) and ARMED (`fill >= len_q`). These are encoded implicitly by `fill`; no separate state register is used.

## Timing
- `o` is registered. It is high in the cycle after the rising edge that sampled the completing bit, and lasts exactly one cycle.
- Back-to-back matches on consecutive valid bits give consecutive `o` pulses. This is possible in overlap mode, for example pattern `11` on the stream `111`.
- `match_cnt` updates on the same edge that sets `o`.
- A `cfg_load` takes effect on the next edge. The first bit considered under the new config is the first valid bit after that edge.
- Gaps with `in_valid = 0` do not break a partial match; history simply holds.

## Configuration
- **Macro:** `SEQ_DETECT_COUNT_EN`.
- **Defined:** `match_cnt` increments by 1 per match and saturates at `2^CNT_W - 1`. The counter resets to 0 only on `rst`.
- **Undefined:** the counter logic is omitted and `match_cnt` is tied to 0. The port remains so the interface is stable.

## Structure
- **Package `seq_detect_pkg`:** holds the reset defaults `SEQ_DEF_PATTERN = 'b1101`, `SEQ_DEF_LEN = 4` and `SEQ_DEF_OVERLAP = 1`, plus a LEN_W helper function.
- **Sub-module `seq_match_cnt`:** a saturating counter with enable. It is instantiated under `SEQ_DETECT_COUNT_EN` only.
- Everything else lives in the top module.

## Test plan
- **Default config:** after reset, stream `1,1,0,1,1,0,1` with `in_valid = 1` throughout. `o` pulses after bit 4 and after bit 7; `match_cnt = 2`.
- **Non-overlap:** load pattern `1101`, len 4, overlap 0, then the same stream. `o` pulses only after bit 4; `match_cnt = 1`.
- **Length and stalls:** load pattern `101101`, len 6, then stream `0,1,0,1,1,0,1` with `in_valid` low for 3 cycles between bits 3 and 4. There is exactly one `o` pulse, after bit 7.
- **Saturation:** with CNT_W = 2, pattern `11` and overlap on, stream six 1s. There are 5 `o` pulses and `match_cnt` holds at 3. With the macro undefined, `match_cnt` stays 0.
- **Reset and load mid-stream:** apply `rst = 0` for one cycle after bits `1,1,0` of `1101`, then feed `1`. No pulse occurs.
  - `cfg_load` with len 0, then feed `1101`: no pulse.
  - `cfg_load` with len 12 when MAX_LEN = 8: `len_q = 8`.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared constants and helpers for the parametrised serial sequence detector.
//   SEQ_DEF_PATTERN / SEQ_DEF_LEN / SEQ_DEF_OVERLAP : config values out of reset
//                                                   (legacy 1101 detector)
//   seq_len_w()                                     : width needed for a length
//                                                   field covering 0..max_len
// -----------------------------------------------------------------------------
package seq_detect_pkg;

  localparam logic [31:0]  SEQ_DEF_PATTERN = 32'b1101;
  localparam int unsigned  SEQ_DEF_LEN     = 4;
  localparam logic         SEQ_DEF_OVERLAP = 1'b1;

  // Bits needed to hold the values 0..max_len inclusive.
  function automatic int unsigned seq_len_w(input int unsigned max_len);
    return 32'($clog2(max_len + 32'd1));
  endfunction

endpackage : seq_detect_pkg

// File: rtl/seq_match_cnt.sv
// -----------------------------------------------------------------------------
// seq_match_cnt
// Saturating up-counter with enable; counts detector matches.
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-low reset (clears count)
//   en   in   increment request for this cycle
//   cnt  out  registered count, sticks at all-ones
// -----------------------------------------------------------------------------
module seq_match_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Count up on enable, holding once the maximum value is reached.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule : seq_match_cnt

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Serial sequence detector with a runtime-programmable pattern and length,
// overlapping or non-overlapping detection, and an optional saturating match
// counter (present only when SEQ_DETECT_COUNT_EN is defined; otherwise
// match_cnt is tied to 0).
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-low reset (priority over all else)
//   i            in   serial data bit
//   in_valid     in   qualifies i; low holds all state
//   cfg_load     in   strobe: latch cfg_* and clear history (same-cycle bit dropped)
//   cfg_pattern  in   pattern, right-aligned; bit [len-1] is the first bit expected
//   cfg_len      in   pattern length; clamped to MAX_LEN, 0 disables detection
//   cfg_overlap  in   1 = overlapping, 0 = non-overlapping detection
//   o            out  registered one-cycle match strobe
//   match_cnt    out  saturating match count (0 when counter is compiled out)
// Controller state is implicit in fill: IDLE (fill==0), FILLING (0<fill<len_q),
// ARMED (fill>=len_q).
// -----------------------------------------------------------------------------
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LEN_W   = seq_len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               o,
  output logic [CNT_W-1:0]   match_cnt
);

  // Reset length, kept legal for very small MAX_LEN builds.
  localparam int unsigned DEF_LEN = (SEQ_DEF_LEN > MAX_LEN) ? MAX_LEN : SEQ_DEF_LEN;

  // Shadow configuration.
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;

  // Datapath.
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] hist_shift_c;
  logic [LEN_W:0]     fill_inc_c;
  logic [MAX_LEN-1:0] cmp_mask_c;
  logic [LEN_W-1:0]   len_clamp_c;
  logic               match_c;

  // Mask selecting the low len bits of a MAX_LEN-wide word.
  function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [MAX_LEN-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      if (k < 32'(len)) m[k] = 1'b1;
    end
    return m;
  endfunction

  // Next history, fill+1 (one bit wider so MAX_LEN+1 never wraps), and match.
  always_comb begin
    hist_shift_c = {hist[MAX_LEN-2:0], i};
    fill_inc_c   = {1'b0, fill} + (LEN_W+1)'(1);
    cmp_mask_c   = len_mask(len_q);
    match_c      = 1'b0;
    if (in_valid && !cfg_load && (len_q != '0) &&
        (fill_inc_c >= {1'b0, len_q}) &&
        (((hist_shift_c ^ pat_q) & cmp_mask_c) == '0)) begin
      match_c = 1'b1;
    end
  end

  // Oversized lengths are clamped at load time.
  always_comb begin
    len_clamp_c = cfg_len;
    if (cfg_len > LEN_W'(MAX_LEN)) len_clamp_c = LEN_W'(MAX_LEN);
  end

  // Config shadow, history, fill and the match strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q <= MAX_LEN'(SEQ_DEF_PATTERN);
      len_q <= LEN_W'(DEF_LEN);
      ovl_q <= SEQ_DEF_OVERLAP;
      hist  <= '0;
      fill  <= '0;
      o     <= 1'b0;
    end else begin
      o <= 1'b0;
      if (cfg_load) begin
        pat_q <= cfg_pattern;
        len_q <= len_clamp_c;
        ovl_q <= cfg_overlap;
        hist  <= '0;
        fill  <= '0;
      end else if (in_valid) begin
        hist <= hist_shift_c;
        o    <= match_c;
        // Non-overlap restarts the fill count so the next match needs len new bits.
        if (match_c && !ovl_q) begin
          fill <= '0;
        end else if (fill != LEN_W'(MAX_LEN)) begin
          fill <= fill_inc_c[LEN_W-1:0];
        end
      end
    end
  end

`ifdef SEQ_DETECT_COUNT_EN
  // Counter enable is the same combinational match that sets o, so both update together.
  seq_match_cnt #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk(clk),
    .rst(rst),
    .en (match_c),
    .cnt(match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule : seq_detect_param
